vga_sync_receiver: RTL
======================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL have parameter LOCK_LINES, default 3: consecutive correctly spaced hsync falls required before vertical lock.
REQ-002 SHALL have parameter WDOG_MAX, default 1023: cycles without an hsync fall before lock is abandoned.
REQ-003 SHALL have port clk, input, 1: single pixel clock; all state on posedge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port h_sync, input, 1: active-low horizontal sync, same clock domain.
REQ-006 SHALL have port v_sync, input, 1: active-low vertical sync, same clock domain.
REQ-007 SHALL have port x_pixel, output, 10: recovered horizontal position, 0..799.
REQ-008 SHALL have port y_pixel, output, 10: recovered vertical position, 0..524.
REQ-009 SHALL have port DE, output, 1: recovered display enable.
REQ-010 SHALL have port locked, output, 1: high while state is LOCKED.
REQ-011 SHALL have port frame_start, output, 1: one-cycle pulse at position (0,0) while locked.
REQ-012 SHALL have port sync_err, output, 1: registered one-cycle pulse on loss of lock.

Function
REQ-013 SHALL register h_sync/v_sync into hs_d/vs_d each cycle; fall = previous sample 1 and current input 0.
REQ-014 SHALL keep h_cnt: on hsync fall, load 657 (sync start 656 + 1); else increment, 799 wraps to 0.
REQ-015 SHALL keep v_cnt: on vsync fall, load 490; else increment when h_cnt wraps 799->0, 524 wraps to 0.
REQ-016 SHALL drive x_pixel = h_cnt and y_pixel = v_cnt directly, no extra latency.
REQ-017 SHALL drive DE = locked && h_cnt < 640 && v_cnt < 480.
REQ-018 SHALL drive frame_start = locked && h_cnt == 0 && v_cnt == 0; exactly one pulse per 420000-cycle frame.
REQ-019 SHALL implement FSM SEARCH, H_ALIGN, LOCKED; locked registered as (state == LOCKED).
REQ-020 SEARCH: first hsync fall -> H_ALIGN, good_lines cleared.
REQ-021 H_ALIGN: on hsync fall, good_lines increments (saturating at LOCK_LINES) if pre-load h_cnt == 656, else clears to 0.
REQ-022 H_ALIGN: vsync fall with good_lines >= LOCK_LINES -> LOCKED; with fewer, stay in H_ALIGN (v_cnt still loaded).
REQ-023 LOCKED: hsync fall with pre-load h_cnt != 656, or vsync fall with pre-load v_cnt != 490 -> SEARCH and sync_err pulse next cycle.
REQ-024 SHALL count cycles since last hsync fall (11-bit, cleared by each fall); reaching WDOG_MAX in H_ALIGN or LOCKED -> SEARCH; LOCKED also pulses sync_err.
REQ-025 Simultaneous hsync and vsync fall: both checks apply in the same cycle; either failure -> SEARCH, single sync_err pulse.
REQ-026 Counters SHALL keep free-running per REQ-014/015 in SEARCH and H_ALIGN.

Reset
REQ-027 Reset SHALL force h_cnt=0, v_cnt=0, hs_d=1, vs_d=1, good_lines=0, watchdog=0, state SEARCH.
REQ-028 During and after reset: x_pixel=0, y_pixel=0, DE=0, locked=0, frame_start=0, sync_err=0; reset mid-frame drops lock immediately, no sync_err pulse.

Structure
REQ-029 Package vga_timing_pkg SHALL hold H_VISIBLE 640, H_FRONT 16, H_SYNC 96, H_BACK 48, H_TOTAL 800, V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, V_TOTAL 525, and the FSM state enum.
REQ-030 Sub-module sync_edge_detect (register plus falling-edge flag) SHALL be instantiated once each for h_sync and v_sync.

Verification
REQ-031 Assert reset mid-frame with the block locked -> all outputs 0 same cycle; state SEARCH.
REQ-032 Drive from the team's 800x525 VGA timing generator on the same clk -> locked rises after first vsync fall (v=490) following >=3 good lines; afterwards x_pixel/y_pixel equal generator counters every cycle.
REQ-033 While locked, over 3 frames -> DE high exactly 640x480 cycles per frame; frame_start pulses every 420000 cycles.
REQ-034 Delay one hsync fall by 1 cycle (h_cnt 657) while locked -> sync_err one cycle, locked 0, relock on next good frame.
REQ-035 Hold h_sync high 1023 cycles while locked -> sync_err pulse, state SEARCH, DE 0.
REQ-036 Inject vsync fall at v_cnt 300 while locked -> sync_err, SEARCH; v_cnt reloaded to 490.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 800x525 VGA timing constants and sync receiver FSM states.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = 525;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;

  typedef enum logic [1:0] {
    SEARCH,
    H_ALIGN,
    LOCKED
  } sync_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Sync input register with falling-edge flag.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic fall
);

  logic sync_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_d <= 1'b1;
    else       sync_d <= sync_in;
  end

  assign fall = sync_d & ~sync_in;

endmodule

// File: rtl/vga_sync_receiver.sv
// Recovers pixel position, DE and lock state from VGA hsync/vsync.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int LOCK_LINES = 3,
  parameter int WDOG_MAX   = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       DE,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  localparam int GW = $clog2(LOCK_LINES + 1);

  localparam logic [9:0]    H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SPOS  = 10'(H_SYNC_START);
  localparam logic [9:0]    H_LOAD  = 10'(H_SYNC_START + 1);
  localparam logic [9:0]    V_SPOS  = 10'(V_SYNC_START);
  localparam logic [9:0]    H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS   = 10'(V_VISIBLE);
  localparam logic [10:0]   WD_LIM  = 11'(WDOG_MAX);
  localparam logic [GW-1:0] GOOD_MX = GW'(LOCK_LINES);

  sync_state_e   state;
  logic          h_fall, v_fall;
  logic [9:0]    h_cnt, v_cnt;
  logic [10:0]   wdog;
  logic [GW-1:0] good_lines;

  logic h_wrap, h_ok, v_ok, wd_trip;

  sync_edge_detect u_hs (
    .clk     (clk),
    .reset   (reset),
    .sync_in (h_sync),
    .fall    (h_fall)
  );

  sync_edge_detect u_vs (
    .clk     (clk),
    .reset   (reset),
    .sync_in (v_sync),
    .fall    (v_fall)
  );

  assign h_wrap  = (h_cnt == H_LAST) && !h_fall;
  assign h_ok    = (h_cnt == H_SPOS);
  assign v_ok    = (v_cnt == V_SPOS);
  assign wd_trip = (wdog == WD_LIM) && !h_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       h_cnt <= '0;
    else if (h_fall) h_cnt <= H_LOAD;
    else if (h_wrap) h_cnt <= '0;
    else             h_cnt <= h_cnt + 10'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       v_cnt <= '0;
    else if (v_fall) v_cnt <= V_SPOS;
    else if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
  end

  // saturates so a dead input cannot wrap back below the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               wdog <= '0;
    else if (h_fall)         wdog <= '0;
    else if (wdog != WD_LIM) wdog <= wdog + 11'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      good_lines <= '0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (h_fall) begin
            state      <= H_ALIGN;
            good_lines <= '0;
          end
        end
        H_ALIGN: begin
          if (wd_trip) begin
            state <= SEARCH;
          end else begin
            if (h_fall) begin
              if (!h_ok)
                good_lines <= '0;
              else if (good_lines != GOOD_MX)
                good_lines <= good_lines + 1'b1;
            end
            if (v_fall && good_lines >= GOOD_MX) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if ((h_fall && !h_ok) || (v_fall && !v_ok) || wd_trip) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  assign x_pixel     = h_cnt;
  assign y_pixel     = v_cnt;
  assign DE          = locked && (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_start = locked && (h_cnt == '0) && (v_cnt == '0);

endmodule
